switch_bank: RTL
================

SWITCH_BANK -- requirements
Module: switch_bank

Interface
REQ-001 SHALL have parameter N_BR, default 2, number of H-bridges driven.
REQ-002 SHALL have parameter DT_W, default 8, width of the deadtime count.
REQ-003 SHALL have parameter INV_MASK, default 2'b10, where bit b=1 swaps the +1/-1 gate patterns of bridge b (secondary polarity).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, run enable.
REQ-007 SHALL have port fault, input, 1, emergency stop request.
REQ-008 SHALL have port fault_clr, input, 1, clears the latched fault.
REQ-009 SHALL have port deadtime, input, DT_W, deadtime length in clocks minus one.
REQ-010 SHALL have port level, input, 2*N_BR, signed 2-bit level per bridge: 01=+1, 00=0, 11=-1, 10=invalid. Bridge b uses bits [2b+1:2b].
REQ-011 SHALL have port gate, output, 4*N_BR, gate drives per bridge. Bridge b uses bits [4b+3:4b].
REQ-012 SHALL have port busy, output, N_BR, bit b is high while bridge b is in deadtime.
REQ-013 SHALL have port fault_latched, output, 1, sticky fault status.

Function
REQ-014 Steady patterns, non-inverted bridge: +1=0110, 0=0101, -1=1001. For an inverted bridge, +1 and -1 are swapped.
REQ-015 Each bridge has an FSM with states STEADY and DEAD, plus registers cur_lvl, tgt_lvl, dt_lat, and a DT_W-bit counter.
REQ-016 In STEADY, gate = pattern(cur_lvl), busy=0, counter=0.
REQ-017 STEADY -> DEAD when the sampled level is valid and differs from cur_lvl. On this edge: tgt_lvl<=level, dt_lat<=deadtime, counter<=0.
REQ-018 In DEAD, gate = pattern(cur_lvl) AND pattern(tgt_lvl), bitwise; this gives 0100/0001/0000 for primary-side transitions. busy=1.
REQ-019 In DEAD, counter increments each clock. When counter==dt_lat: next state is STEADY and cur_lvl<=tgt_lvl. DEAD therefore lasts exactly dt_lat+1 clocks; deadtime=0 gives 1 clock.
REQ-020 Level changes during DEAD are ignored. The level is resampled in the first STEADY cycle after DEAD.
REQ-021 Changes to deadtime during DEAD do not affect the running transition, because dt_lat is used.
REQ-022 The invalid level code 10 is ignored: the state is held and no transition occurs.
REQ-023 Level latency: a change sampled at edge k shows the DEAD pattern after edge k. The new steady pattern appears after edge k+dt_lat+1.
REQ-024 fault=1 does all of the following:
- forces every gate to 0000 combinationally, in the same cycle;
- sets fault_latched at the next edge;
- puts every FSM in STEADY with cur_lvl=0.
REQ-025 While fault_latched=1, gates stay 0000 and level is ignored. fault_latched clears on an edge with fault_clr=1 and fault=0. If fault and fault_clr are both high, fault wins.
REQ-026 en=0 does all of the following:
- forces gates to 0000;
- holds every FSM in STEADY with cur_lvl=0;
- leaves fault_latched unchanged.
REQ-027 On the first enabled, fault-free cycle, gate = level-0 pattern (0101). A nonzero level then follows REQ-017.
REQ-028 No output bit pattern other than those in REQ-014 and REQ-018, or all-zero, SHALL ever appear on any bridge.

Reset
REQ-029 When rst_n=0, asynchronously: gate=0, busy=0, fault_latched=0, every FSM in STEADY, cur_lvl=tgt_lvl=0, counter=0, dt_lat=0.
REQ-030 Reset mid-DEAD abandons the transition. After release with en=1, gate=0101.

Structure
REQ-031 A shared package switch_pkg SHALL hold:
- the level codes;
- the three steady pattern constants;
- the STEADY/DEAD state encoding;
- a pattern(level, invert) function.
REQ-032 A sub-module bridge_leg_fsm SHALL implement one bridge (REQ-015 to REQ-022). It is instantiated N_BR times via generate. Fault/en gating and fault_latched SHALL live in the top level.

Verification
REQ-033 Scenario 1: N_BR=2, deadtime=3, en=1, bridge 0 level 0 -> +1.
- Response: gate[3:0]=0100 for 4 clocks, then 0110, with busy[0]=1 for 4 clocks.
REQ-034 Scenario 2: bridge 1 (inverted) level +1 -> -1, deadtime=0.
- Response: gate[7:4]=0000 for 1 clock, then 0110.
REQ-035 Scenario 3: level toggles back mid-DEAD, and deadtime changes 3 -> 10 mid-DEAD.
- Response: the transition completes after 4 clocks, then a new DEAD is entered toward the latest level.
REQ-036 Scenario 4: fault pulse while bridge 0 is at +1.
- Response: gates 0000 in the same cycle; fault_latched=1 persists until fault_clr.
- After fault_clr: gates 0101.
REQ-037 Scenario 5: level=10 applied to either bridge.
- Response: no state change and no busy.
REQ-038 Scenario 6: rst_n asserted mid-DEAD.
- Response: gates 0000 immediately; 0101 on the first clock after release.

Source files
------------

// File: rtl/switch_pkg.sv
// ----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the H-bridge switch bank:
//   - signed 2-bit level codes (+1, 0, -1, invalid)
//   - steady-state gate patterns for a non-inverted bridge
//   - per-leg FSM state encoding
//   - pattern(level, invert) helper that maps a level code to gate drives
// ----------------------------------------------------------------------------
package switch_pkg;

    localparam logic [1:0] LVL_ZERO = 2'b00;
    localparam logic [1:0] LVL_POS  = 2'b01;
    localparam logic [1:0] LVL_NEG  = 2'b11;
    localparam logic [1:0] LVL_INV  = 2'b10;

    localparam logic [3:0] PAT_POS  = 4'b0110;
    localparam logic [3:0] PAT_ZERO = 4'b0101;
    localparam logic [3:0] PAT_NEG  = 4'b1001;

    typedef enum logic {
        STEADY = 1'b0,
        DEAD   = 1'b1
    } leg_state_t;

    // An inverted bridge (secondary polarity) swaps the +1 and -1 patterns.
    // The invalid code never reaches a register, but maps to all-off anyway.
    function automatic logic [3:0] pattern(input logic [1:0] lvl, input logic invert);
        logic [3:0] pat;
        case (lvl)
            LVL_POS:  pat = invert ? PAT_NEG : PAT_POS;
            LVL_ZERO: pat = PAT_ZERO;
            LVL_NEG:  pat = invert ? PAT_POS : PAT_NEG;
            default:  pat = 4'b0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bridge_leg_fsm.sv
// ----------------------------------------------------------------------------
// bridge_leg_fsm
// One H-bridge: holds the current level, and on a valid level change walks
// through a deadtime interval before committing the new level.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   hold         : force STEADY at level 0 (fault / disable from the top)
//   level [1:0]  : requested signed level code
//   deadtime     : deadtime length in clocks minus one
//   gate  [3:0]  : raw gate pattern (not yet fault/enable gated)
//   busy         : high while in deadtime
// ----------------------------------------------------------------------------
module bridge_leg_fsm
    import switch_pkg::*;
#(
    parameter int   DT_W   = 8,
    parameter logic INVERT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic [1:0]      level,
    input  logic [DT_W-1:0] deadtime,
    output logic [3:0]      gate,
    output logic            busy
);

    leg_state_t      state, state_nx;
    logic [1:0]      cur_lvl, cur_nx;
    logic [1:0]      tgt_lvl, tgt_nx;
    logic [DT_W-1:0] dt_lat, dt_nx;
    logic [DT_W-1:0] count, count_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STEADY;
            cur_lvl <= LVL_ZERO;
            tgt_lvl <= LVL_ZERO;
            dt_lat  <= '0;
            count   <= '0;
        end else begin
            state   <= state_nx;
            cur_lvl <= cur_nx;
            tgt_lvl <= tgt_nx;
            dt_lat  <= dt_nx;
            count   <= count_nx;
        end
    end

    // Level changes are only looked at in STEADY, so anything requested
    // during deadtime is picked up on the first STEADY cycle afterwards.
    // The deadtime length is latched on entry so mid-transition edits of
    // the deadtime input cannot stretch or cut the running interval.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_lvl;
        tgt_nx   = tgt_lvl;
        dt_nx    = dt_lat;
        count_nx = count;
        gate     = pattern(cur_lvl, INVERT);
        busy     = 1'b0;

        if (hold) begin
            state_nx = STEADY;
            cur_nx   = LVL_ZERO;
            count_nx = '0;
        end else begin
            case (state)
                STEADY: begin
                    count_nx = '0;
                    if (level != LVL_INV && level != cur_lvl) begin
                        state_nx = DEAD;
                        tgt_nx   = level;
                        dt_nx    = deadtime;
                    end
                end
                DEAD: begin
                    if (count == dt_lat) begin
                        state_nx = STEADY;
                        cur_nx   = tgt_lvl;
                        count_nx = '0;
                    end else begin
                        count_nx = count + DT_W'(1);
                    end
                end
                default: begin
                    state_nx = STEADY;
                    count_nx = '0;
                end
            endcase
        end

        // Only switches that are on in both the old and new pattern stay on,
        // which keeps both devices of a leg off during the swap.
        if (state == DEAD) begin
            gate = pattern(cur_lvl, INVERT) & pattern(tgt_lvl, INVERT);
            busy = 1'b1;
        end
    end

endmodule

// File: rtl/switch_bank.sv
// ----------------------------------------------------------------------------
// switch_bank
// Bank of N_BR H-bridges with per-bridge deadtime insertion, a latched
// emergency stop and a run enable.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : run enable (0 forces all gates off, levels to 0)
//   fault         : emergency stop, kills gates combinationally
//   fault_clr     : clears the latched fault when fault is low
//   deadtime      : deadtime length in clocks minus one
//   level         : 2-bit signed level per bridge, bridge b at [2b+1:2b]
//   gate          : 4 gate drives per bridge, bridge b at [4b+3:4b]
//   busy          : bit b high while bridge b is in deadtime
//   fault_latched : sticky fault status
// ----------------------------------------------------------------------------
module switch_bank
    import switch_pkg::*;
#(
    parameter int              N_BR     = 2,
    parameter int              DT_W     = 8,
    parameter logic [N_BR-1:0] INV_MASK = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic [DT_W-1:0]   deadtime,
    input  logic [2*N_BR-1:0] level,
    output logic [4*N_BR-1:0] gate,
    output logic [N_BR-1:0]   busy,
    output logic              fault_latched
);

    logic hold;
    logic gate_off;

    // Fault takes priority over clear so a held fault can never be cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    assign hold     = fault | fault_latched | ~en;
    // Reset is included so the gates drop with rst_n without waiting for
    // the leg registers, independent of en.
    assign gate_off = hold | ~rst_n;

    for (genvar b = 0; b < N_BR; b++) begin : g_leg
        logic [3:0] leg_gate;
        logic       leg_busy;

        bridge_leg_fsm #(
            .DT_W   (DT_W),
            .INVERT (INV_MASK[b])
        ) u_leg (
            .clk      (clk),
            .rst_n    (rst_n),
            .hold     (hold),
            .level    (level[2*b +: 2]),
            .deadtime (deadtime),
            .gate     (leg_gate),
            .busy     (leg_busy)
        );

        assign gate[4*b +: 4] = gate_off ? 4'b0000 : leg_gate;
        assign busy[b]        = leg_busy;
    end

endmodule
